// File: rtl/uart_rx_config_set.sv
// uart_rx_config_set: 8N1 UART receiver plus a 4-byte packet parser
// (sync, index, value, checksum). Each good packet writes one byte of the
// live 32-bit configuration bus busNow.
module uart_rx_config_set #(
    parameter int unsigned CLK_HZ       = 10000000,
    parameter int unsigned BAUD         = 115200,
    parameter int unsigned CLKS_PER_BIT = CLK_HZ / BAUD,
    parameter logic [7:0]  SYNC_BYTE    = 8'h55,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        uRx,
    input  logic [31:0] busDefault,
    output logic [31:0] busNow,
    output logic        cfgUpdate,
    output logic [7:0]  rxByte,
    output logic        rxValid,
    output logic        frameErr,
    output logic        pktErr
);

    localparam int unsigned GAP_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int unsigned CNT_W     = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned GAP_W     = $clog2(GAP_LIMIT + 1);

    // Counters load (N-1) and fire on zero, so a load of N-1 means N clocks.
    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST    = GAP_W'(GAP_LIMIT - 1);

    typedef enum logic [2:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP,
        R_BREAK
    } rx_state_t;

    typedef enum logic [1:0] {
        P_SYNC,
        P_IDX,
        P_VAL,
        P_SUM
    } pkt_state_t;

    logic             r_rxMeta;
    logic             r_rxS;

    rx_state_t        r_rxState;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bitIdx;
    logic [7:0]       r_shift;
    logic [7:0]       r_rxByte;
    logic             r_rxValid;
    logic             r_frameErr;

    pkt_state_t       r_pState;
    logic [7:0]       r_idx;
    logic [7:0]       r_val;
    logic [GAP_W-1:0] r_gap;
    logic [31:0]      r_busNow;
    logic             r_cfgUpdate;
    logic             r_pktErr;

    logic [7:0]       w_sum;
    logic             w_idxOk;

    assign w_sum   = r_idx + r_val;
    assign w_idxOk = (r_idx[7:2] == '0);

    assign busNow    = r_busNow;
    assign cfgUpdate = r_cfgUpdate;
    assign rxByte    = r_rxByte;
    assign rxValid   = r_rxValid;
    assign frameErr  = r_frameErr;
    assign pktErr    = r_pktErr;

    // Two-flop synchroniser for the asynchronous serial line; idles high.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            r_rxMeta <= 1'b1;
            r_rxS    <= 1'b1;
        end else begin
            r_rxMeta <= uRx;
            r_rxS    <= r_rxMeta;
        end
    end

    // Receive FSM: mid-bit sampling of start, 8 data bits LSB first, stop.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            r_rxState  <= R_IDLE;
            r_cnt      <= '0;
            r_bitIdx   <= '0;
            r_shift    <= '0;
            r_rxByte   <= '0;
            r_rxValid  <= 1'b0;
            r_frameErr <= 1'b0;
        end else begin
            r_rxValid  <= 1'b0;
            r_frameErr <= 1'b0;
            case (r_rxState)
                R_IDLE: begin
                    if (!r_rxS) begin
                        r_cnt     <= HALF_RELOAD;
                        r_rxState <= R_START;
                    end
                end
                R_START: begin
                    if (r_cnt == '0) begin
                        if (r_rxS) begin
                            r_rxState <= R_IDLE;
                        end else begin
                            r_cnt     <= BIT_RELOAD;
                            r_bitIdx  <= '0;
                            r_rxState <= R_DATA;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                R_DATA: begin
                    if (r_cnt == '0) begin
                        r_shift <= {r_rxS, r_shift[7:1]};
                        r_cnt   <= BIT_RELOAD;
                        if (r_bitIdx == 3'd7) begin
                            r_rxState <= R_STOP;
                        end else begin
                            r_bitIdx <= r_bitIdx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                R_STOP: begin
                    if (r_cnt == '0) begin
                        if (r_rxS) begin
                            r_rxByte  <= r_shift;
                            r_rxValid <= 1'b1;
                            r_rxState <= R_IDLE;
                        end else begin
                            r_frameErr <= 1'b1;
                            r_rxState  <= R_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                R_BREAK: begin
                    if (r_rxS) begin
                        r_rxState <= R_IDLE;
                    end
                end
                default: r_rxState <= R_IDLE;
            endcase
        end
    end

    // Packet parser: frame errors and inter-byte timeout resync to P_SYNC.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            r_pState    <= P_SYNC;
            r_idx       <= '0;
            r_val       <= '0;
            r_gap       <= '0;
            r_busNow    <= busDefault;
            r_cfgUpdate <= 1'b0;
            r_pktErr    <= 1'b0;
        end else begin
            r_cfgUpdate <= 1'b0;
            r_pktErr    <= 1'b0;
            if (r_frameErr) begin
                r_pState <= P_SYNC;
                r_gap    <= '0;
            end else if (r_rxValid) begin
                r_gap <= '0;
                case (r_pState)
                    P_SYNC: begin
                        if (r_rxByte == SYNC_BYTE) begin
                            r_pState <= P_IDX;
                        end
                    end
                    P_IDX: begin
                        r_idx    <= r_rxByte;
                        r_pState <= P_VAL;
                    end
                    P_VAL: begin
                        r_val    <= r_rxByte;
                        r_pState <= P_SUM;
                    end
                    P_SUM: begin
                        if ((r_rxByte == w_sum) && w_idxOk) begin
                            r_busNow[{r_idx[1:0], 3'b000} +: 8] <= r_val;
                            r_cfgUpdate <= 1'b1;
                        end else begin
                            r_pktErr <= 1'b1;
                        end
                        r_pState <= P_SYNC;
                    end
                    default: r_pState <= P_SYNC;
                endcase
            end else if (r_pState != P_SYNC) begin
                if (r_gap == GAP_LAST) begin
                    r_pState <= P_SYNC;
                    r_gap    <= '0;
                end else begin
                    r_gap <= r_gap + 1'b1;
                end
            end else begin
                r_gap <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_config_set.sv
// tb_uart_rx_config_set: directed packets against a packet-level model.
`timescale 1ns/1ps
module tb_uart_rx_config_set;

    localparam int CPB = 86;

    logic        clk = 1'b0;
    logic        nRst;
    logic        uRx;
    logic [31:0] busDefault;
    logic [31:0] busNow;
    logic        cfgUpdate;
    logic [7:0]  rxByte;
    logic        rxValid;
    logic        frameErr;
    logic        pktErr;

    uart_rx_config_set #(
        .CLK_HZ       (10000000),
        .BAUD         (115200),
        .SYNC_BYTE    (8'h55),
        .TIMEOUT_BITS (20)
    ) dut (
        .clk        (clk),
        .nRst       (nRst),
        .uRx        (uRx),
        .busDefault (busDefault),
        .busNow     (busNow),
        .cfgUpdate  (cfgUpdate),
        .rxByte     (rxByte),
        .rxValid    (rxValid),
        .frameErr   (frameErr),
        .pktErr     (pktErr)
    );

    always #50 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Packet-level model: bytes collected since a sync byte, expectations
    // for every pulse the DUT should produce, and the expected bus value.
    logic [7:0]  pkt[$];
    logic [7:0]  exp_bytes[$];
    logic [15:0] exp_writes[$];
    int          exp_ferr = 0;
    int          exp_perr = 0;
    logic [31:0] model_bus;
    bit          started = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic void model_clear_pkt();
        pkt.delete();
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        logic [7:0] s;
        exp_bytes.push_back(b);
        if (pkt.size() == 0 && b != 8'h55) return;
        pkt.push_back(b);
        if (pkt.size() == 4) begin
            s = pkt[1] + pkt[2];
            if (pkt[3] == s && pkt[1] < 8'd4) exp_writes.push_back({pkt[1], pkt[2]});
            else exp_perr++;
            pkt.delete();
        end
    endfunction

    function automatic void model_reset();
        pkt.delete();
        exp_bytes.delete();
        exp_writes.delete();
        exp_ferr  = 0;
        exp_perr  = 0;
        model_bus = busDefault;
    endfunction

    task automatic bit_time(input logic v);
        uRx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop = 0);
        if (bad_stop) begin
            exp_ferr++;
            model_clear_pkt();
        end else begin
            model_byte(b);
        end
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
        bit_time(bad_stop ? 1'b0 : 1'b1);
        if (bad_stop) begin
            bit_time(1'b1);
            bit_time(1'b1);
        end
    endtask

    task automatic send_pkt(input logic [7:0] a, b, c, d);
        send_byte(a);
        send_byte(b);
        send_byte(c);
        send_byte(d);
    endtask

    task automatic idle_bits(input int n);
        uRx = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic check_drained(input string tag);
        chk({tag, "_bytes_left"}, exp_bytes.size(), 0);
        chk({tag, "_writes_left"}, exp_writes.size(), 0);
        chk({tag, "_ferr_left"}, exp_ferr, 0);
        chk({tag, "_perr_left"}, exp_perr, 0);
    endtask

    // Per-cycle comparison of DUT outputs against the model.
    initial begin : compare
        logic [15:0] w;
        logic        prev_valid;
        prev_valid = 1'b0;
        wait (started);
        forever begin
            @(posedge clk);
            #1;
            if (rxValid) begin
                n_checks++;
                if (exp_bytes.size() == 0) begin
                    $display("FAIL rxValid_unexpected: got 1 expected 0 at %0t", $time);
                end else begin
                    n_pass++;
                    chk("rxByte", rxByte, exp_bytes.pop_front());
                end
                chk("rxValid_frameErr_overlap", frameErr, 1'b0);
            end
            if (cfgUpdate) begin
                chk("cfgUpdate_latency", prev_valid, 1'b1);
                n_checks++;
                if (exp_writes.size() == 0) begin
                    $display("FAIL cfgUpdate_unexpected: got 1 expected 0 at %0t", $time);
                end else begin
                    n_pass++;
                    w = exp_writes.pop_front();
                    model_bus[w[9:8]*8 +: 8] = w[7:0];
                end
            end
            if (frameErr) begin
                n_checks++;
                if (exp_ferr == 0) $display("FAIL frameErr_unexpected: got 1 expected 0 at %0t", $time);
                else begin n_pass++; exp_ferr--; end
            end
            if (pktErr) begin
                chk("pktErr_latency", prev_valid, 1'b1);
                n_checks++;
                if (exp_perr == 0) $display("FAIL pktErr_unexpected: got 1 expected 0 at %0t", $time);
                else begin n_pass++; exp_perr--; end
            end
            chk("busNow", busNow, model_bus);
            prev_valid = rxValid;
        end
    end

    initial begin : watchdog
        #20ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        nRst       = 1'b0;
        uRx        = 1'b1;
        busDefault = 32'h0132000A;
        repeat (3) @(negedge clk);
        model_reset();
        nRst = 1'b1;

        // 1: reset state
        chk("rst_busNow", busNow, 32'h0132000A);
        chk("rst_rxByte", rxByte, 8'h00);
        chk("rst_pulses", {rxValid, cfgUpdate, frameErr, pktErr}, 4'b0000);
        started = 1;
        idle_bits(2);

        // 2: good packet, back-to-back bytes
        send_pkt(8'h55, 8'h01, 8'h3C, 8'h3D);
        idle_bits(2);
        check_drained("t2");
        chk("t2_bus", busNow, 32'h01323C0A);

        // 3: bad sum, bad index, wrapping sum
        busDefault = 32'hDEADBEEF;
        send_pkt(8'h55, 8'h02, 8'h10, 8'h99);
        send_pkt(8'h55, 8'h04, 8'h00, 8'h04);
        idle_bits(2);
        check_drained("t3_err");
        chk("t3_err_bus", busNow, 32'h01323C0A);
        send_pkt(8'h55, 8'h02, 8'hFF, 8'h01);
        idle_bits(2);
        check_drained("t3_wrap");
        chk("t3_wrap_bus", busNow, 32'h01FF3C0A);

        // 4: stop-bit error mid-packet, then a clean packet
        send_byte(8'h55);
        send_byte(8'h03);
        send_byte(8'h12, 1);
        send_pkt(8'h55, 8'h03, 8'h00, 8'h03);
        idle_bits(2);
        check_drained("t4");
        chk("t4_bus", busNow, 32'h00FF3C0A);

        // 5: inter-byte timeout, then non-sync bytes; then a short glitch
        send_byte(8'h55);
        send_byte(8'h00);
        idle_bits(25);
        model_clear_pkt();
        send_byte(8'h7F);
        send_byte(8'h7F);
        idle_bits(2);
        uRx = 1'b0;
        repeat (30) @(negedge clk);
        idle_bits(3);
        check_drained("t5");
        chk("t5_bus", busNow, 32'h00FF3C0A);

        // 6: reset in the middle of byte 3, then resend
        busDefault = 32'h0132000A;
        send_byte(8'h55);
        send_byte(8'h01);
        bit_time(1'b0);
        for (int i = 0; i < 4; i++) bit_time(i == 2 || i == 3);
        nRst = 1'b0;
        model_reset();
        @(negedge clk);
        nRst = 1'b1;
        uRx  = 1'b1;
        chk("t6_rst_bus", busNow, 32'h0132000A);
        idle_bits(3);
        check_drained("t6_rst");
        send_pkt(8'h55, 8'h01, 8'h3C, 8'h3D);
        idle_bits(2);
        check_drained("t6");
        chk("t6_bus", busNow, 32'h01323C0A);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
